demux_write_sched: RTL

//  Scheduler in front of the 16-way destination demux. Queues write requests
//  (4-bit destination + data) from a single producer in a small FIFO.

---
 rtl/demux_write_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/demux_write_sched.sv
// demux_write_sched: write scheduler in front of a 16-way destination demux.
//
// Write requests (4-bit destination + data) from one producer go into a small FIFO.
// The scheduler issues them one at a time. For each write it drives the demux select,
// the data and a one-hot strobe. It holds the write until the addressed destination
// acks or a timeout expires.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (synchronous release)
//   req_valid/req_ready  producer handshake; ready = FIFO not full
//   req_dest, req_data   request destination index and write data
//   sel, data_out        demux select and data (hold last value while idle)
//   strobe               one-hot write strobe (bit sel) while waiting for ack
//   ack                  per-destination acknowledge; only ack[sel] is honoured
//   busy                 FSM waiting or FIFO non-empty
//   err                  sticky: some write timed out
//   count                FIFO occupancy
//   dest_mask, drop_cnt  only with DWS_MASK_EN: masked destinations are dropped on
//                        pop and counted (saturating)
//
// Build option: define DWS_MASK_EN to enable destination masking.
module demux_write_sched #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_dest,
  input  logic [DW-1:0]            req_data,
  output logic [3:0]               sel,
  output logic [DW-1:0]            data_out,
  output logic [15:0]              strobe,
  input  logic [15:0]              ack,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
`ifdef DWS_MASK_EN
  ,
  input  logic [15:0]              dest_mask,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [7:0]      r_timer, w_timer_nxt;
  logic [3:0]      r_sel, w_sel_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic            r_err, w_err_nxt;
  logic [3:0]      r_mem_dest [DEPTH];
  logic [DW-1:0]   r_mem_data [DEPTH];

  logic            w_push, w_pop, w_issue;
  logic [3:0]      w_head_dest;
  logic [DW-1:0]   w_head_data;

  assign w_head_dest = r_mem_dest[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  // Ready comes from the registered count only, so a full FIFO never accepts,
  // even in a cycle where the head is being popped.
  assign req_ready = (r_count < CW'(DEPTH));
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == StIdle) && (r_count != '0);

`ifdef DWS_MASK_EN
  logic [7:0] r_drop_cnt;
  // A popped entry with a masked destination is discarded without issuing.
  assign w_issue = w_pop && dest_mask[w_head_dest];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_pop && !dest_mask[w_head_dest] && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign w_issue = w_pop;
`endif

  // Entry storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dest[r_wr_ptr] <= req_dest;
      r_mem_data[r_wr_ptr] <= req_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_sel_nxt   = r_sel;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_issue) begin
          w_sel_nxt   = w_head_dest;
          w_data_nxt  = w_head_data;
          w_timer_nxt = '0;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (ack[r_sel]) begin
          w_state_nxt = StIdle;
        end else if (r_timer == 8'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_timer  <= '0;
      r_sel    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_timer  <= w_timer_nxt;
      r_sel    <= w_sel_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  assign sel      = r_sel;
  assign data_out = r_data;
  assign strobe   = (r_state == StWait) ? (16'h0001 << r_sel) : 16'h0000;
  assign busy     = (r_state != StIdle) || (r_count != '0);
  assign err      = r_err;
  assign count    = r_count;

endmodule
